// File: rtl/display_scan_ctrl.sv
// Converts a 14-bit binary value to four BCD digits (double dabble) and
// multiplexes them onto a 4-digit active-low seven-segment display.
//
// state | meaning
// IDLE  | waiting for a value; in_ready high
// CONV  | one shift-and-add-3 step per cycle, 14 steps
// LOAD  | copy BCD result and overflow flag to the display registers
module display_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] in_value,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        busy
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t state_q, state_d;

    logic        xfer, conv_en, load_en, last_iter;
    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        ovf_pend_q;
    logic [15:0] digits_q;
    logic        ovf_q;
    logic [15:0] bcd_adj;
    logic [15:0] bcd_shift;
    logic [13:0] bin_shift;

    logic [PW-1:0] pre_q;
    logic [1:0]    idx_q;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    cur_digit;
    logic          blank_sel;
    logic          z1, z2, z3;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign last_iter = (cnt_q == 4'd13);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CONV;
            CONV:    if (last_iter) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        conv_en  = 1'b0;
        load_en  = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            CONV: begin
                busy    = 1'b1;
                conv_en = 1'b1;
            end
            LOAD: begin
                busy    = 1'b1;
                load_en = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign xfer = in_valid & in_ready;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[14:0], bin_q[13]};
        bin_shift = {bin_q[12:0], 1'b0};
    end

    // Overflow is decided from the raw value; the 16-bit BCD result is meaningless above 9999.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (xfer) begin
                bin_q      <= in_value;
                bcd_q      <= '0;
                cnt_q      <= '0;
                ovf_pend_q <= (in_value > 14'd9999);
            end
            if (conv_en) begin
                bin_q <= bin_shift;
                bcd_q <= bcd_shift;
                cnt_q <= cnt_q + 4'd1;
            end
            if (load_en) begin
                digits_q <= bcd_q;
                ovf_q    <= ovf_pend_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    assign z3 = (digits_q[15:12] == 4'd0);
    assign z2 = z3 & (digits_q[11:8] == 4'd0);
    assign z1 = z2 & (digits_q[7:4] == 4'd0);

    always_comb begin
        cur_digit = digits_q[3:0];
        blank_sel = 1'b0;
        case (idx_q)
            2'd1: begin cur_digit = digits_q[7:4];   blank_sel = z1; end
            2'd2: begin cur_digit = digits_q[11:8];  blank_sel = z2; end
            2'd3: begin cur_digit = digits_q[15:12]; blank_sel = z3; end
            default: begin cur_digit = digits_q[3:0]; blank_sel = 1'b0; end
        endcase
    end

    always_comb begin
        seg_d = SEG_BLANK;
        case (cur_digit)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = SEG_BLANK;
        endcase
        if (ovf_q)                      seg_d = SEG_DASH;
        else if (blank_lz && blank_sel) seg_d = SEG_BLANK;
        an_d = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= 4'b1111;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;

endmodule
